// File: rtl/logic_arb_pkg.sv
// Shared opcode and FSM state encodings for the logic unit arbiter.
package logic_arb_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/result bundle between requesters and the logic unit arbiter.
// LOGIC_ARB_LOCK_EN adds the per-requester req_lock signal.
interface logic_unit_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
`ifdef LOGIC_ARB_LOCK_EN
  logic [NUM_REQ-1:0]       req_lock;
`endif
  logic                     res_valid;
  logic                     res_ready;
  logic [WIDTH-1:0]         res_data;
  logic [ID_W-1:0]          res_id;

  modport master (
`ifdef LOGIC_ARB_LOCK_EN
    output req_lock,
`endif
    output req_valid, req_op, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
`ifdef LOGIC_ARB_LOCK_EN
    input  req_lock,
`endif
    input  req_valid, req_op, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  int unsigned     pos;
  logic [ID_W-1:0] pos_w;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    pos_w = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos   = (32'(ptr_i) + k) % NUM_REQ;
      pos_w = ID_W'(pos);
      if (!any_o && req_i[pos_w]) begin
        any_o        = 1'b1;
        idx_o        = pos_w;
        gnt_o[pos_w] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered AND/OR/XOR/NAND unit among NUM_REQ requesters.
// Define LOGIC_ARB_LOCK_EN to let a locked winner keep the round-robin pointer.
module logic_unit_arbiter
  import logic_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ID_W    = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  logic_unit_arbiter_if.slave  bus
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   win_q;
  op_e               op_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              res_valid_q;
  logic [WIDTH-1:0]  res_data_q;
  logic [ID_W-1:0]   res_id_q;
  logic              locked;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic               accept;
  logic [1:0]         sel_op;
  logic [WIDTH-1:0]   sel_a, sel_b, alu;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign accept        = (state_q == ST_IDLE) && pick_any && !rst_i;
  assign bus.req_ready = accept ? pick_gnt : '0;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;

  // One-hot grant steers the winner's operands onto the capture path.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (pick_gnt[i]) begin
        sel_op = bus.req_op[2*i +: 2];
        sel_a  = bus.req_a[WIDTH*i +: WIDTH];
        sel_b  = bus.req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    alu = '0;
    unique case (op_q)
      OP_AND:  alu = a_q & b_q;
      OP_OR:   alu = a_q | b_q;
      OP_XOR:  alu = a_q ^ b_q;
      OP_NAND: alu = ~(a_q & b_q);
      default: alu = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: if (pick_any) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: begin
        if (bus.res_ready) begin
          state_d = ST_IDLE;
          if (locked) ptr_d = win_q;
          else if (win_q == ID_W'(NUM_REQ - 1)) ptr_d = '0;
          else ptr_d = win_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef LOGIC_ARB_LOCK_EN
  logic lock_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)       lock_q <= 1'b0;
    else if (accept) lock_q <= |(pick_gnt & bus.req_lock);
  end
  assign locked = lock_q;
`else
  assign locked = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      op_q        <= OP_AND;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (accept) begin
        win_q <= pick_idx;
        op_q  <= op_e'(sel_op);
        a_q   <= sel_a;
        b_q   <= sel_b;
      end
      if (state_q == ST_EXEC) begin
        res_valid_q <= 1'b1;
        res_data_q  <= alu;
        res_id_q    <= win_q;
      end else if (state_q == ST_DONE && bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed cases plus randomized traffic
// checked against a round-robin reference model.
module tb_logic_unit_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_unit_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) bus ();

  logic_unit_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (W),
    .ID_W    (IW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int mdl_ptr = 0;

  logic [1:0]   op_v   [N];
  logic [W-1:0] a_v    [N];
  logic [W-1:0] b_v    [N];
  logic [N-1:0] lock_v = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_op[2*i +: 2] = op_v[i];
      bus.req_a[W*i +: W]  = a_v[i];
      bus.req_b[W*i +: W]  = b_v[i];
    end
`ifdef LOGIC_ARB_LOCK_EN
    bus.req_lock = lock_v;
`endif
  endtask

  // Called one time unit after a rising edge with the DUT idle.
  task automatic txn(input logic [N-1:0] vld, input int w, input int hold,
                     input bit use_exp, input logic [W-1:0] exp_data);
    logic [W-1:0] ed;
    logic [N-1:0] eg;
    logic         lk;
    bus.req_valid = vld;
    drive();
    #1;
    ed    = use_exp ? exp_data : ref_op(op_v[w], a_v[w], b_v[w]);
    eg    = '0;
    eg[w] = 1'b1;
    lk    = lock_v[w];
    chk("grant_ready", 64'(bus.req_ready), 64'(eg));
    @(posedge clk); #1;
    chk("exec_ready", 64'(bus.req_ready), 64'd0);
    chk("exec_valid", 64'(bus.res_valid), 64'd0);
    @(posedge clk); #1;
    chk("done_valid", 64'(bus.res_valid), 64'd1);
    chk("done_data", 64'(bus.res_data), 64'(ed));
    chk("done_id", 64'(bus.res_id), 64'(w));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(bus.res_valid), 64'd1);
      chk("hold_data", 64'(bus.res_data), 64'(ed));
      chk("hold_id", 64'(bus.res_id), 64'(w));
      chk("hold_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk("hs_valid", 64'(bus.res_valid), 64'd0);
`ifdef LOGIC_ARB_LOCK_EN
    mdl_ptr = lk ? w : (w + 1) % N;
`else
    if (lk) mdl_ptr = (w + 1) % N;
    else    mdl_ptr = (w + 1) % N;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_ptr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      op_v[i] = '0;
      a_v[i]  = '0;
      b_v[i]  = '0;
    end
    rst           = 1'b1;
    bus.req_valid = '1;
    bus.res_ready = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_res_data", 64'(bus.res_data), 64'd0);
    chk("rst_res_id", 64'(bus.res_id), 64'd0);
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", 64'(bus.req_ready), 64'd0);
    chk("idle_valid", 64'(bus.res_valid), 64'd0);

    // Single NAND op on requester 0.
    op_v[0] = 2'b11; a_v[0] = 32'hFFFF0000; b_v[0] = 32'hFF00FF00;
    txn(4'b0001, 0, 0, 1'b1, 32'h00FFFFFF);

    // Opcode sweep.
    a_v[0] = 32'hF0F0F0F0; b_v[0] = 32'hFF00FF00;
    op_v[0] = 2'b00; txn(4'b0001, 0, 0, 1'b1, 32'hF000F000);
    op_v[0] = 2'b01; txn(4'b0001, 0, 0, 1'b1, 32'hFFF0FFF0);
    op_v[0] = 2'b10; txn(4'b0001, 0, 0, 1'b1, 32'h0FF00FF0);
    op_v[0] = 2'b11; txn(4'b0001, 0, 0, 1'b1, 32'h0FFF0FFF);

    // Round-robin with all requesters valid.
    do_reset();
    for (int i = 0; i < N; i++) begin
      op_v[i] = 2'($urandom_range(0, 3));
      a_v[i]  = $urandom;
      b_v[i]  = $urandom;
    end
    for (int k = 0; k < 5; k++) txn(4'b1111, k % N, 0, 1'b0, '0);

    // Backpressure in DONE for five cycles.
    txn(4'b1111, 1, 5, 1'b0, '0);

    // Reset while EXEC: result abandoned, pointer back to 0.
    bus.req_valid = 4'b0100;
    drive();
    #1;
    chk("pre_rst_grant", 64'(bus.req_ready), 64'h4);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_valid", 64'(bus.res_valid), 64'd0);
    @(posedge clk); #1;
    chk("midrst_valid2", 64'(bus.res_valid), 64'd0);
    chk("midrst_ready", 64'(bus.req_ready), 64'd0);
    mdl_ptr = 0;
    txn(4'b1010, 1, 0, 1'b0, '0);

`ifdef LOGIC_ARB_LOCK_EN
    do_reset();
    lock_v = 4'b0010;
    txn(4'b0110, 1, 0, 1'b0, '0);
    txn(4'b0110, 1, 0, 1'b0, '0);
    lock_v = 4'b0000;
    txn(4'b0110, 1, 0, 1'b0, '0);
    txn(4'b0110, 2, 0, 1'b0, '0);
`endif

    // Randomized traffic against the reference model.
    for (int t = 0; t < 40; t++) begin
      logic [N-1:0] vld;
      vld = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        op_v[i] = 2'($urandom_range(0, 3));
        a_v[i]  = $urandom;
        b_v[i]  = $urandom;
      end
`ifdef LOGIC_ARB_LOCK_EN
      lock_v = N'($urandom_range(0, (1 << N) - 1));
`endif
      if (vld == '0) begin
        bus.req_valid = '0;
        drive();
        @(posedge clk); #1;
        chk("rand_idle_ready", 64'(bus.req_ready), 64'd0);
        chk("rand_idle_valid", 64'(bus.res_valid), 64'd0);
      end else begin
        txn(vld, pick(vld, mdl_ptr), $urandom_range(0, 2), 1'b0, '0);
      end
    end

    bus.req_valid = '0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one registered bitwise logic unit (AND/OR/XOR/NAND) among NUM_REQ requesters in the RISC-V datapath, e.g. the execute stage, CSR unit and debug port.
- Requesters are arbitrated round-robin; one operation is in flight at a time.
- Each result is returned on a valid/ready output channel tagged with the requester index.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand and result width in bits.
- ID_W, 2, width of RES_ID; must equal ceil(log2(NUM_REQ)), minimum 1.

Ports:
- CLK  input  1  single clock; all state changes on rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ_VALID  input  NUM_REQ  per-requester request valid.
- REQ_READY  output  NUM_REQ  per-requester accept; one-hot or zero.
- REQ_OP  input  2*NUM_REQ  opcode per requester; requester i uses bits [2i+1:2i].
- REQ_A  input  WIDTH*NUM_REQ  operand A per requester, packed the same way.
- REQ_B  input  WIDTH*NUM_REQ  operand B per requester, packed the same way.
- RES_VALID  output  1  result valid.
- RES_READY  input  1  consumer accepts result.
- RES_DATA  output  WIDTH  registered result.
- RES_ID  output  ID_W  index of the requester that owns RES_DATA.

Behaviour:
- Opcodes: 00 AND, 01 OR, 10 XOR, 11 NAND (~(A&B)). All are bitwise over WIDTH bits; no carries or flags.
- FSM has three states:
  - IDLE: a winner exists if any REQ_VALID is high. The winner is the first valid index at or after pointer PTR, wrapping modulo NUM_REQ. REQ_READY[winner] is asserted combinationally in the same cycle. On that edge, OP/A/B and the winner index are captured and the FSM goes to EXEC. With no valid request, the FSM stays in IDLE.
  - EXEC: on the next edge, RES_DATA is loaded with op(A,B), RES_ID with the winner and RES_VALID with 1, and the FSM goes to DONE.
  - DONE: RES_VALID, RES_DATA and RES_ID hold stable until RES_READY=1. On that handshake edge: RES_VALID goes to 0, PTR becomes (winner+1) mod NUM_REQ, and the FSM returns to IDLE.
- Latency: an accept at edge N gives RES_VALID=1 after edge N+1. Minimum issue interval is 3 cycles.
- REQ_READY is 0 in EXEC and DONE. At most one bit is ever set.
- Requesters hold VALID/OP/A/B stable until READY. If VALID drops before grant, arbitration simply re-evaluates each IDLE cycle; nothing is captured.
- Fairness: a requester that holds VALID is granted within NUM_REQ grants.
- RES_READY is ignored outside DONE.
- Reset values: state IDLE, PTR=0, RES_VALID=0, RES_DATA=0, RES_ID=0, REQ_READY=0.
- Reset during EXEC or DONE abandons the operation; no result is produced.
- PTR is only updated on the result handshake.

Optional Feature:
- Macro: LOGIC_ARB_LOCK_EN.
- Defined: adds input REQ_LOCK [NUM_REQ]. If REQ_LOCK[winner] is high when the request is accepted, PTR is set to the winner (not winner+1) on the result handshake. This lets the same requester win again and issue atomic multi-op sequences.
- Lock is only honoured while that requester keeps VALID high in the following IDLE cycle. Otherwise normal round-robin from the winner resumes.
- Not defined: the port is absent and PTR always advances to winner+1.

Decomposition:
- Shared package logic_arb_pkg holds:
  - opcode constants OP_AND/OP_OR/OP_XOR/OP_NAND;
  - FSM state encoding ST_IDLE/ST_EXEC/ST_DONE.
- One sub-module: rr_priority_picker.
  - Inputs: request vector and PTR.
  - Outputs: one-hot grant, encoded index and any_valid.
  - Purely combinational.
- The arbiter FSM and result registers stay in logic_unit_arbiter.

Test Plan:
- Single op: reset, then REQ_VALID=0001, OP=11, A=0xFFFF0000, B=0xFF00FF00. Expect REQ_READY=0001 in that cycle; two edges later RES_VALID=1, RES_DATA=0x00FFFFFF, RES_ID=0.
- Opcode sweep: A=0xF0F0F0F0, B=0xFF00FF00. Expect AND 0xF000F000, OR 0xFFF0FFF0, XOR 0x0FF00FF0, NAND 0x0FFF0FFF.
- Round-robin: REQ_VALID=1111 held continuously. Grant order 0,1,2,3,0 with RES_ID following the same order; never two READY bits high.
- Backpressure: hold RES_READY=0 for 5 cycles in DONE. RES_VALID, RES_DATA and RES_ID stay constant; REQ_READY=0000 throughout; advance occurs only on the RES_READY=1 edge.
- Reset mid-op: assert RST in EXEC. Next cycle RES_VALID=0, PTR=0, and the next grant with REQ_VALID=1010 goes to index 1.
- Lock (LOGIC_ARB_LOCK_EN defined): REQ_VALID=0110, REQ_LOCK=0010. Requester 1 is granted three times consecutively. When REQ_LOCK[1] drops, the next grant goes to 2.
